// File: rtl/grant_finish_unit_if.sv
// grant_finish_unit_if: grant-in, grant-out, finish-enqueue and status signals of grant_finish_unit
interface grant_finish_unit_if #(
    parameter int BEATS     = 4,
    parameter int DATA_W    = 64,
    parameter int FIN_DEPTH = 2
);
    localparam int AW = $clog2(BEATS);
    localparam int CW = $clog2(FIN_DEPTH) + 1;
    logic              gin_valid, gin_ready, gin_manager_id, gin_builtin;
    logic [1:0]        gin_xact_id;
    logic [3:0]        gin_g_type;
    logic [AW-1:0]     gin_addr_beat;
    logic [DATA_W-1:0] gin_data;
    logic              gout_valid, gout_ready, gout_manager_id, gout_builtin;
    logic [1:0]        gout_xact_id;
    logic [3:0]        gout_g_type;
    logic [AW-1:0]     gout_addr_beat;
    logic [DATA_W-1:0] gout_data;
    logic              fin_valid, fin_ready, fin_manager_id;
    logic [1:0]        fin_manager_xact_id;
    logic [CW-1:0]     fin_count;
    logic              protocol_err;
    modport slave (
        input  gin_valid, gin_xact_id, gin_manager_id, gin_builtin, gin_g_type, gin_addr_beat, gin_data,
        output gin_ready,
        output gout_valid, gout_xact_id, gout_manager_id, gout_builtin, gout_g_type, gout_addr_beat, gout_data,
        input  gout_ready,
        output fin_valid, fin_manager_xact_id, fin_manager_id, fin_count, protocol_err,
        input  fin_ready
    );
    modport master (
        output gin_valid, gin_xact_id, gin_manager_id, gin_builtin, gin_g_type, gin_addr_beat, gin_data,
        input  gin_ready,
        input  gout_valid, gout_xact_id, gout_manager_id, gout_builtin, gout_g_type, gout_addr_beat, gout_data,
        output gout_ready,
        input  fin_valid, fin_manager_xact_id, fin_manager_id, fin_count, protocol_err,
        output fin_ready
    );
endinterface

// File: rtl/grant_finish_unit.sv
// grant_finish_unit: grant pass-through with beat counting and a local FIFO of finish records
module grant_finish_unit #(
    parameter int BEATS     = 4,
    parameter int DATA_W    = 64,
    parameter int FIN_DEPTH = 2
) (
    input logic clk,
    input logic reset,
    grant_finish_unit_if.slave g
);
    localparam int AW = $clog2(BEATS);
    localparam int CW = $clog2(FIN_DEPTH) + 1;
    localparam int PW = FIN_DEPTH > 1 ? $clog2(FIN_DEPTH) : 1;
    logic [AW-1:0] beat_cnt;
    logic [PW-1:0] enq_ptr, deq_ptr;
    logic [CW-1:0] count;
    logic [2:0]    mem [FIN_DEPTH];
    logic          multibeat, needs_finish, last, fin_gen, space, block, fire, push, pop, err;
    always_comb begin
        multibeat    = g.gin_builtin ? g.gin_g_type == 4'd5 : g.gin_g_type != 4'd2;
        needs_finish = !(g.gin_builtin && g.gin_g_type == 4'd0);
        last         = !multibeat || beat_cnt == AW'(BEATS - 1);
        fin_gen      = needs_finish && last;
        // only registered occupancy counts: a same-cycle pop does not open a slot
        space        = count < CW'(FIN_DEPTH);
        block        = fin_gen && !space;
        fire         = g.gin_valid && g.gout_ready && !block;
        push         = fire && fin_gen;
        pop          = count != '0 && g.fin_ready;
    end
    assign g.gout_valid          = g.gin_valid && !block;
    assign g.gin_ready           = g.gout_ready && !block;
    assign g.gout_xact_id        = g.gin_xact_id;
    assign g.gout_manager_id     = g.gin_manager_id;
    assign g.gout_builtin        = g.gin_builtin;
    assign g.gout_g_type         = g.gin_g_type;
    assign g.gout_addr_beat      = g.gin_addr_beat;
    assign g.gout_data           = g.gin_data;
    assign g.fin_valid           = count != '0;
    assign g.fin_manager_xact_id = mem[deq_ptr][2:1];
    assign g.fin_manager_id      = mem[deq_ptr][0];
    assign g.fin_count           = count;
    assign g.protocol_err        = err;
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            enq_ptr  <= '0;
            deq_ptr  <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            if (fire && multibeat) beat_cnt <= last ? '0 : beat_cnt + AW'(1);
            if (fire && g.gin_addr_beat != (multibeat ? beat_cnt : AW'(0))) err <= 1'b1;
            if (push) begin
                mem[enq_ptr] <= {g.gin_xact_id, g.gin_manager_id};
                enq_ptr      <= enq_ptr == PW'(FIN_DEPTH - 1) ? '0 : enq_ptr + PW'(1);
            end
            if (pop) deq_ptr <= deq_ptr == PW'(FIN_DEPTH - 1) ? '0 : deq_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: doc/grant_finish_unit.md
Name: grant_finish_unit

Overview:
- Sits directly upstream of the single-entry finish queue, on the client side of the TileLink-style grant channel.
- Passes grant beats from the manager to the client unchanged.
- Counts beats of multibeat grants.
- Once the final beat of each grant that needs acknowledgement is accepted, generates one finish record {manager_xact_id, manager_id} into a small local FIFO.
- The FIFO drains into the finish-queue enqueue port.

Parameters:
- BEATS, 4, beats per multibeat grant; power of 2, ≥2.
- DATA_W, 64, grant data width.
- FIN_DEPTH, 2, local finish FIFO entries; ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- gin_valid  in  1  grant beat valid from manager
- gin_ready  out  1  grant beat accepted
- gin_xact_id  in  2  manager_xact_id
- gin_manager_id  in  1  manager id
- gin_builtin  in  1  built-in grant type flag
- gin_g_type  in  4  grant type
- gin_addr_beat  in  log2(BEATS)  beat index
- gin_data  in  DATA_W  beat data
- gout_valid  out  1  beat to client
- gout_ready  in  1  client ready
- gout_xact_id, gout_manager_id, gout_builtin, gout_g_type, gout_addr_beat, gout_data  out  (same widths)  copies of gin_* fields
- fin_valid  out  1  finish record valid (to finish-queue enq)
- fin_ready  in  1  finish-queue enq ready
- fin_manager_xact_id  out  2  finish xact id
- fin_manager_id  out  1  finish manager id
- fin_count  out  log2(FIN_DEPTH)+1  local FIFO occupancy
- protocol_err  out  1  sticky beat-index mismatch flag

Behaviour:
- Reset is synchronous and active-high on clock clk.
  - Reset values: beat_cnt=0, FIFO empty, fin_valid=0, fin_count=0, protocol_err=0.
  - Reset mid-grant drops the partial grant and any queued finishes.
- Classification (combinational, current beat):
  - multibeat = gin_builtin ? (gin_g_type==5) : (gin_g_type!=2).
  - needs_finish = !(gin_builtin && gin_g_type==0).
  - last = !multibeat || beat_cnt==BEATS-1.
  - fin_gen = needs_finish && last.
- Grant pass-through, zero latency:
  - space = fin_count < FIN_DEPTH. Registered state only; a dequeue in the same cycle does not free a slot.
  - block = fin_gen && !space.
  - gout_valid = gin_valid && !block.
  - gin_ready = gout_ready && !block.
  - All gout_* data fields are wired straight from gin_*.
  - fire = gin_valid && gin_ready.
- Beat counter:
  - On fire && multibeat: beat_cnt wraps to 0 when last, else increments.
  - Single-beat grants leave beat_cnt unchanged.
  - On fire, if gin_addr_beat != (multibeat ? beat_cnt : 0), protocol_err sets to 1 and holds until reset. Data flow is unaffected.
- Finish FIFO:
  - Circular buffer with enq_ptr, deq_ptr, count.
  - Push {gin_xact_id, gin_manager_id} on fire && fin_gen.
  - fin_valid = count!=0. Head entry is driven from registers; no bypass, so a finish appears at the earliest 1 cycle after the last beat fires.
  - Pop on fin_valid && fin_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIN_DEPTH.
  - Records leave in grant-completion order.
- No grant beats are interleaved: one grant completes before the next begins.

Test Plan:
- Single-beat grant, builtin=0, g_type=2, xact_id=2, manager_id=1; gout_ready=1 → gout_valid the same cycle, beat_cnt stays 0. Next cycle fin_valid=1, xact=2, id=1; fin_ready=1 pops it, fin_count 1→0.
- Builtin g_type=0 voluntary ack → passes through, no finish generated, fin_count stays 0.
- Multibeat builtin g_type=5, beats 0..3 with xact_id=1 → exactly one finish, appearing 1 cycle after beat 3 fires. beat_cnt sequence is 0,1,2,3,0.
- fin_ready=0, three single-beat needs-finish grants (xact 0,1,2):
  - First two accepted, fin_count=2.
  - Third is held with gin_ready=0 and gout_valid=0.
  - Raise fin_ready for one cycle → the cycle after that pop, the third beat is accepted. Finishes pop in order 0,1,2.
- Multibeat grant with beat 2 sent carrying addr_beat=3 → protocol_err=1 and stays 1. One finish is still generated after the fourth beat.
- Assert reset after beat 1 of a multibeat grant with fin_count=1 → next cycle beat_cnt=0, fin_count=0, fin_valid=0. A following fresh 4-beat grant completes normally.
